// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: LCR field positions, TX FSM states,
// oversampling ratio and the frame parity rule.
package uart_pkg;

    localparam int UartOversample = 16;

    localparam int LcrWlsLsb = 0;
    localparam int LcrWlsMsb = 1;
    localparam int LcrStb    = 2;
    localparam int LcrPen    = 3;
    localparam int LcrEps    = 4;
    localparam int LcrSp     = 5;
    localparam int LcrBrk    = 6;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // Only the low 5..8 bits selected by the word length take part in parity.
    function automatic logic tx_parity(input logic [7:0] data, input logic [1:0] wls,
                                       input logic eps, input logic stick);
        logic [7:0] mask;
        mask = 8'hff >> (2'd3 - wls);
        if (stick) begin
            return ~eps;
        end
        return eps ? ^(data & mask) : ~^(data & mask);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the transmitter; capacity can be cut to a single holding register.
module uart_tx_fifo #(
    parameter int Depth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    cap_one_i,
    input  logic [7:0]              data_i,
    output logic [7:0]              data_o,
    output logic [$clog2(Depth):0]  level_o,
    output logic                    empty_o
);

    localparam int PtrW = $clog2(Depth);
    localparam logic [PtrW:0] DepthLevel = (PtrW + 1)'(Depth);

    logic [7:0]      mem [Depth];
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;
    logic [PtrW:0]   level;
    logic            full;
    logic            push_ok;
    logic            pop_ok;

    assign empty_o = (level == '0);
    assign full    = cap_one_i ? !empty_o : (level >= DepthLevel);

    // A pop in the same cycle frees the slot a full-FIFO push needs; clear beats both.
    assign pop_ok  = pop_i && !empty_o && !clear_i;
    assign push_ok = push_i && (!full || pop_ok) && !clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (clear_i) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            level <= level + (PtrW + 1)'(push_ok) - (PtrW + 1)'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wptr] <= data_i;
    end

    assign data_o  = mem[rptr];
    assign level_o = level;

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: baud divider, TX FIFO and the framing FSM that drives txd_o.
import uart_pkg::*;

module uart_tx #(
    parameter int FifoDepth = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [7:0]                  thr_i,
    input  logic                        thr_write_i,
    input  logic [7:0]                  lcr_i,
    input  logic [7:0]                  dll_i,
    input  logic [7:0]                  dlm_i,
    input  logic                        dllm_write_i,
    input  logic                        fifo_en_i,
    input  logic                        tx_fifo_rst_i,
    output logic                        tx_fifo_rst_clr_o,
    output logic                        txd_o,
    output logic                        thre_o,
    output logic                        temt_o,
    output logic [$clog2(FifoDepth):0]  fifo_level_o
);

    localparam logic [3:0] LastTick = 4'(UartOversample - 1);

    logic [15:0] divisor;
    logic [15:0] baud_cnt;
    logic        tick;

    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_ready;
    logic        pop;

    tx_state_e   state, state_d;
    logic [3:0]  sub_cnt, sub_d;
    logic [2:0]  bit_idx, bit_idx_d;
    logic        stop_half, stop_half_d;
    logic        stop_done;
    logic        txd_q, txd_d;
    logic [7:0]  shifter, shifter_d;
    logic [1:0]  wls, wls_d;
    logic        pen, pen_d;
    logic        stb, stb_d;
    logic        par_bit, par_bit_d;

    // DLAB selects register banks upstream and has no meaning here.
    logic        lcr_unused;
    assign lcr_unused = lcr_i[7];

    assign divisor = {dlm_i, dll_i};
    assign tick    = (divisor != 16'd0) && (baud_cnt == divisor - 16'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            baud_cnt <= '0;
        end else if (dllm_write_i || tick || divisor == 16'd0) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

    uart_tx_fifo #(.Depth(FifoDepth)) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (tx_fifo_rst_i),
        .push_i   (thr_write_i),
        .pop_i    (pop),
        .cap_one_i(!fifo_en_i),
        .data_i   (thr_i),
        .data_o   (fifo_data),
        .level_o  (fifo_level_o),
        .empty_o  (fifo_empty)
    );

    // A FIFO being flushed this cycle must not hand its head to the shifter.
    assign fifo_ready = !fifo_empty && !tx_fifo_rst_i;

    always_comb begin
        state_d     = state;
        sub_d       = sub_cnt;
        bit_idx_d   = bit_idx;
        stop_half_d = stop_half;
        shifter_d   = shifter;
        wls_d       = wls;
        pen_d       = pen;
        stb_d       = stb;
        par_bit_d   = par_bit;
        pop         = 1'b0;
        stop_done   = 1'b0;
        txd_d       = 1'b1;

        case (state)
            TX_IDLE: begin
                if (tick && fifo_ready) pop = 1'b1;
            end
            TX_START: begin
                if (tick) begin
                    sub_d = sub_cnt + 4'd1;
                    if (sub_cnt == LastTick) begin
                        state_d   = TX_DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    sub_d = sub_cnt + 4'd1;
                    if (sub_cnt == LastTick) begin
                        if (bit_idx == {1'b0, wls} + 3'd4) begin
                            state_d     = pen ? TX_PARITY : TX_STOP;
                            stop_half_d = 1'b0;
                        end else begin
                            bit_idx_d = bit_idx + 3'd1;
                            shifter_d = shifter >> 1;
                        end
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    sub_d = sub_cnt + 4'd1;
                    if (sub_cnt == LastTick) begin
                        state_d     = TX_STOP;
                        stop_half_d = 1'b0;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    sub_d = sub_cnt + 4'd1;
                    if (sub_cnt == LastTick) stop_half_d = 1'b1;
                    // Two stop bits: a second 8-tick half for 5-bit words, a full 16 otherwise.
                    if (!stb)             stop_done = (sub_cnt == LastTick);
                    else if (wls == 2'd0) stop_done = stop_half && (sub_cnt == 4'd7);
                    else                  stop_done = stop_half && (sub_cnt == LastTick);
                    if (stop_done) begin
                        sub_d = '0;
                        if (fifo_ready) pop = 1'b1;
                        else            state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase

        if (pop) begin
            state_d   = TX_START;
            sub_d     = '0;
            shifter_d = fifo_data;
            wls_d     = lcr_i[LcrWlsMsb:LcrWlsLsb];
            pen_d     = lcr_i[LcrPen];
            stb_d     = lcr_i[LcrStb];
            par_bit_d = tx_parity(fifo_data, lcr_i[LcrWlsMsb:LcrWlsLsb], lcr_i[LcrEps], lcr_i[LcrSp]);
        end

        // Line level is derived from the next state so it changes on the same edge as the FSM.
        case (state_d)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = shifter_d[0];
            TX_PARITY: txd_d = par_bit_d;
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= TX_IDLE;
            sub_cnt   <= '0;
            bit_idx   <= '0;
            stop_half <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state     <= state_d;
            sub_cnt   <= sub_d;
            bit_idx   <= bit_idx_d;
            stop_half <= stop_half_d;
            txd_q     <= txd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shifter <= shifter_d;
        wls     <= wls_d;
        pen     <= pen_d;
        stb     <= stb_d;
        par_bit <= par_bit_d;
    end

    assign txd_o             = txd_q & ~lcr_i[LcrBrk];
    assign thre_o            = fifo_empty;
    assign temt_o            = fifo_empty && (state == TX_IDLE);
    assign tx_fifo_rst_clr_o = tx_fifo_rst_i;

endmodule
